// File: rtl/note_pkg.sv
// Shared types and constants for the note pattern generator and its LFSR.
package note_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          ROW_W     = 16;

endpackage

// File: rtl/note_pattern_gen_lfsr16.sv
// 16-bit Galois LFSR (right shift). Reset restores RESET_VAL; load takes the seed port.
module lfsr16
    import note_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (reset)
            value <= RESET_VAL;
        else if (load)
            value <= seed;
        else if (advance)
            value <= (value >> 1) ^ (value[0] ? LFSR_MASK : 16'h0000);
    end

endmodule

// File: rtl/note_pattern_gen.sv
// Column pattern feeder: tick divider, run/pause/idle FSM and LFSR note placement
// with a minimum blank gap after each note.
module note_pattern_gen
    import note_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned GAP_MIN   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [1:0]       speed,
    output logic [ROW_W-1:0] pattern_out,
    output logic             shift_en,
    output logic [15:0]      step_count,
    output logic             running
);

    localparam int TW = $clog2(TICK_DIV + 1);

    state_e        state;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] period;
    logic [TW-1:0] period_m1;
    logic [3:0]    gap_cnt;
    logic [15:0]   lfsr;
    logic          lfsr_load;
    logic          step_fire;

    // Period floors at 1 so a large speed shift never yields a zero-length step.
    always_comb begin
        period = TW'(TICK_DIV >> speed);
        if (period == '0)
            period = TW'(1);
        period_m1 = period - TW'(1);
    end

    // stop and pause both outrank a step landing on the same edge.
    assign step_fire = (state == RUN) && !stop && !pause && (tick_cnt >= period_m1);
    assign lfsr_load = (state == IDLE) && !stop && start;

    lfsr16 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (LFSR_SEED),
        .advance (step_fire),
        .value   (lfsr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pattern_out <= '0;
            shift_en    <= 1'b0;
            step_count  <= '0;
            running     <= 1'b0;
            tick_cnt    <= '0;
            gap_cnt     <= '0;
        end else begin
            shift_en <= 1'b0;
            if (stop) begin
                state       <= IDLE;
                pattern_out <= '0;
                running     <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        tick_cnt   <= '0;
                        gap_cnt    <= '0;
                        step_count <= '0;
                    end
                    RUN: if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end else if (step_fire) begin
                        tick_cnt   <= '0;
                        shift_en   <= 1'b1;
                        step_count <= step_count + 16'd1;
                        // Decision uses the LFSR value before this step's advance.
                        if (gap_cnt != 4'd0) begin
                            pattern_out <= '0;
                            gap_cnt     <= gap_cnt - 4'd1;
                        end else if (lfsr[0]) begin
                            pattern_out <= ROW_W'(1) << lfsr[4:1];
                            gap_cnt     <= 4'(GAP_MIN);
                        end else begin
                            pattern_out <= '0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                    PAUSED: if (!pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/note_pattern_gen.md
Name: note_pattern_gen

Overview:
Upstream feeder for the 16x16 column shift display. Generates one 16-bit column pattern per game step and a one-cycle shift-enable pulse. Together these drive the column shifter's pattern_in/enable pair.
Step timing comes from a programmable tick divider. Note placement comes from a 16-bit Galois LFSR, with an enforced minimum gap of blank columns after every note. A small run/pause/idle FSM gates all activity.

Parameters:
TICK_DIV, 1_000_000, base clk cycles per step at speed=0; must be >= 8
LFSR_SEED, 16'hACE1, LFSR load value on reset and on IDLE->RUN; must be nonzero
GAP_MIN, 2, number of forced blank steps after each emitted note (0..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high; clock clk
start  input  1  level; IDLE->RUN request
stop  input  1  level; any state -> IDLE
pause  input  1  level; RUN<->PAUSED while held/released
speed  input  2  step period = TICK_DIV >> speed
pattern_out  output  16  current column pattern; held between steps
shift_en  output  1  one-cycle pulse per step; pattern_out valid in same cycle
step_count  output  16  steps issued since last start, wraps 16'hFFFF->0
running  output  1  high when state==RUN

Behaviour:
- Reset values: state=IDLE, pattern_out=0, shift_en=0, step_count=0, running=0, tick_cnt=0, gap_cnt=0, lfsr=LFSR_SEED.
- FSM states are IDLE, RUN and PAUSED. Input priority: reset > stop > pause > start.
- IDLE: start=1 -> RUN. The same edge clears tick_cnt, gap_cnt and step_count, and loads lfsr=LFSR_SEED. pause is ignored in IDLE.
- RUN: pause=1 -> PAUSED. tick_cnt holds its value; no shift_en is issued in PAUSED.
- PAUSED: pause=0 -> RUN. tick_cnt resumes from the held value.
- stop=1 in any state -> IDLE, pattern_out<=0, shift_en<=0. step_count and lfsr hold their values.
- Period P = max(TICK_DIV >> speed, 1). speed is sampled every cycle; a change takes effect on the next compare.
- In RUN, tick_cnt increments each cycle. When tick_cnt >= P-1 (>= covers a speed increase mid-count), tick_cnt<=0 and a step fires. All step outputs are registered:
  - shift_en<=1 for exactly one cycle
  - step_count<=step_count+1
  - pattern_out<=new pattern
  - lfsr advances
- Latency: the first shift_en is high in cycle P after the start edge. Subsequent pulses come every P cycles.
- Step decision uses the pre-advance lfsr value L:
  - gap_cnt != 0: pattern=16'h0000, gap_cnt<=gap_cnt-1
  - gap_cnt == 0 and L[0]==1: pattern=16'h0001 << L[4:1], gap_cnt<=GAP_MIN
  - gap_cnt == 0 and L[0]==0: pattern=16'h0000
- LFSR advance is a Galois right shift with mask 16'hB400: lfsr <= (L>>1) ^ (L[0] ? 16'hB400 : 0).
- shift_en=0 on every non-step cycle. pattern_out holds its last value between steps.
- step_count wrap: 16'hFFFF+1 -> 0; no flag is raised.
- Simultaneous stop and step edge: stop wins; no pulse, pattern_out=0.
- Simultaneous pause and step edge: pause wins; tick_cnt holds at P-1 and the step fires on the first RUN cycle after release.
- Reset mid-operation returns all registers to their reset values on the next edge.

Decomposition:
- Package note_pkg holds:
  - state enum (IDLE, RUN, PAUSED)
  - LFSR_MASK = 16'hB400
  - ROW_W = 16
- Sub-module lfsr16 is natural: ports clk, reset, load, seed, advance, value. It is reused by the later scoring/randomizer blocks.
- The divider and FSM stay in the top module.

Test Plan:
1. Reset, then TICK_DIV=8, speed=0, start for 1 cycle -> shift_en pulses in cycles 8, 16, 24, each exactly 1 cycle wide. step_count reads 1, 2, 3 after the pulses.
2. Seed ACE1, GAP_MIN=2, steps 1..6 -> pattern_out = 0001, 0000, 0000, 0000, 0000, 0008. The LFSR sequence is ACE1, E270, 7138, 389C, 1C4E, 0E27.
3. Assert pause after 5 RUN cycles, hold 20 cycles, release -> no shift_en during pause; the next pulse comes 3 cycles after release; pattern_out is unchanged during pause.
4. TICK_DIV=8: speed=3 -> period 1 (shift_en high every cycle); speed=2 -> period 2.
5. stop asserted on the same cycle tick_cnt==P-1 -> no pulse, pattern_out=0, running=0. A new start replays the pattern sequence from the seed (step 1 pattern = 0001).
6. Force step_count to FFFF (run 65535 steps at speed=3), one more step -> step_count=0000. reset mid-run -> all outputs 0 on the next cycle.
